wbm_regs: RTL and testbench

WBM_REGS -- requirements
Module: wbm_regs

---
 rtl/wbm_pkg.sv | 37 +++
 rtl/wbm_chan_regs.sv | 114 +++++++++++
 rtl/wbm_regs.sv | 134 +++++++++++++
 tb/tb_wbm_regs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// wbm_pkg: shared definitions for the Wishbone DMA register slice.
//   Word offsets within a channel's 8-word window, CCR/CSR bit positions,
//   the access FSM state encoding and a byte-lane merge helper.
package wbm_pkg;

    localparam logic [2:0] W_CCR   = 3'd0;
    localparam logic [2:0] W_CSR   = 3'd1;
    localparam logic [2:0] W_DAR   = 3'd2;
    localparam logic [2:0] W_NDAR  = 3'd3;
    localparam logic [2:0] W_STATE = 3'd4;
    localparam logic [2:0] W_DESC  = 3'd5;
    localparam logic [2:0] W_ADDR  = 3'd6;
    localparam logic [2:0] W_NEXT  = 3'd7;

    localparam int CCR_START   = 0;
    localparam int CCR_IE_DONE = 1;
    localparam int CCR_IE_ERR  = 2;

    localparam int CSR_DONE = 0;
    localparam int CSR_ERR  = 1;
    localparam int CSR_BUSY = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } wbm_state_e;

    // Replace the byte lanes enabled in sel, keep the rest of old.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] m;
        m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/wbm_chan_regs.sv
// wbm_chan_regs: register set of one DMA channel.
//   clk_i, rst_n_i      clock, async active-low reset
//   wr_en_i             commit a write this cycle to word_i
//   word_i              word offset (used for both write and read mux)
//   sel_i, dat_i        byte lanes and write data
//   done_i, err_i       single-cycle engine events
//   state_i..next_i     engine status, read-only
//   rd_dat_o            read value of word_i
//   ccr_o, dar_o, ndar_o current register contents
//   start_o             one-cycle start pulse
//   irq_term_o          this channel's interrupt contribution
module wbm_chan_regs
    import wbm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_en_i,
    input  logic [2:0]  word_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    input  logic        done_i,
    input  logic        err_i,
    input  logic [7:0]  state_i,
    input  logic [15:0] desc_i,
    input  logic [28:0] addr_i,
    input  logic [28:0] next_i,
    output logic [31:0] rd_dat_o,
    output logic [31:0] ccr_o,
    output logic [28:0] dar_o,
    output logic [28:0] ndar_o,
    output logic        start_o,
    output logic        irq_term_o
);

    logic [31:0] ccr_q, ccr_d;
    logic [28:0] dar_q, dar_d, ndar_q, ndar_d;
    logic        done_q, done_d, err_q, err_d, start_q, start_d;
    logic [28:0] mask29;

    // Byte-lane mask restricted to address bits [31:3].
    assign mask29 = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {5{sel_i[0]}}};

    always_comb begin
        ccr_d   = ccr_q;
        dar_d   = dar_q;
        ndar_d  = ndar_q;
        done_d  = done_q;
        err_d   = err_q;
        start_d = 1'b0;
        if (wr_en_i) begin
            case (word_i)
                W_CCR: begin
                    ccr_d            = merge_bytes(ccr_q, dat_i, sel_i);
                    ccr_d[CCR_START] = 1'b0;
                    start_d          = sel_i[0] & dat_i[CCR_START];
                end
                W_CSR: begin
                    if (sel_i[0] && dat_i[CSR_DONE]) done_d = 1'b0;
                    if (sel_i[0] && dat_i[CSR_ERR])  err_d  = 1'b0;
                end
                W_DAR:   dar_d  = (dar_q  & ~mask29) | (dat_i[31:3] & mask29);
                W_NDAR:  ndar_d = (ndar_q & ~mask29) | (dat_i[31:3] & mask29);
                default: ;
            endcase
        end
        // Events applied last so they win over a same-cycle clear.
        if (done_i) done_d = 1'b1;
        if (err_i)  err_d  = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ccr_q   <= '0;
            dar_q   <= '0;
            ndar_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            ccr_q   <= ccr_d;
            dar_q   <= dar_d;
            ndar_q  <= ndar_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        rd_dat_o = '0;
        case (word_i)
            W_CCR:   rd_dat_o = ccr_q;
            W_CSR: begin
                rd_dat_o[CSR_BUSY] = |state_i;
                rd_dat_o[CSR_ERR]  = err_q;
                rd_dat_o[CSR_DONE] = done_q;
            end
            W_DAR:   rd_dat_o = {dar_q, 3'b000};
            W_NDAR:  rd_dat_o = {ndar_q, 3'b000};
            W_STATE: rd_dat_o = {24'h0, state_i};
            W_DESC:  rd_dat_o = {16'h0, desc_i};
            W_ADDR:  rd_dat_o = {addr_i, 3'b000};
            W_NEXT:  rd_dat_o = {next_i, 3'b000};
            default: rd_dat_o = '0;
        endcase
    end

    assign ccr_o      = ccr_q;
    assign dar_o      = dar_q;
    assign ndar_o     = ndar_q;
    assign start_o    = start_q;
    assign irq_term_o = (done_q & ccr_q[CCR_IE_DONE]) | (err_q & ccr_q[CCR_IE_ERR]);

endmodule

// File: rtl/wbm_regs.sv
// wbm_regs: Wishbone slave register block for NCH DMA channels.
//   wb_clk_i, wb_rst_n_i       clock, async active-low reset
//   wbs_*                      Wishbone slave (cab ignored, rty tied 0)
//   sg_*_i                     packed per-channel engine status (read-only)
//   ch_done_i, ch_err_i        per-channel completion/error events
//   ccr_o, dar_o, ndar_o       packed per-channel register contents
//   start_o, irq_o             start pulses, registered interrupt
//
// state   | meaning
// IDLE    | waiting for cyc&stb; decode, commit write, capture read data
// RESP    | one-cycle ack or err with registered data, then back to IDLE
module wbm_regs
    import wbm_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic             wbs_cab_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    output logic             wbs_err_o,
    output logic             wbs_rty_o,
    input  logic [NCH*8-1:0]  sg_state_i,
    input  logic [NCH*16-1:0] sg_desc_i,
    input  logic [NCH*29-1:0] sg_addr_i,
    input  logic [NCH*29-1:0] sg_next_i,
    input  logic [NCH-1:0]    ch_done_i,
    input  logic [NCH-1:0]    ch_err_i,
    output logic [NCH*32-1:0] ccr_o,
    output logic [NCH*29-1:0] dar_o,
    output logic [NCH*29-1:0] ndar_o,
    output logic [NCH-1:0]    start_o,
    output logic              irq_o
);

    wbm_state_e      state_q, state_d;
    logic            ack_q, ack_d, err_q, err_d, irq_q;
    logic [31:0]     dat_q, dat_d, rd_sel;
    logic [CHW-1:0]  chan;
    logic [2:0]      word;
    logic            chan_ok, req, take;
    logic [31:0]     rd_dat [NCH];
    logic [NCH-1:0]  irq_term, wr_en;
    logic            unused_ok;

    assign chan    = wbs_adr_i[5+CHW-1:5];
    assign word    = wbs_adr_i[4:2];
    assign chan_ok = (32'(chan) < 32'(NCH));
    assign req     = wbs_cyc_i & wbs_stb_i;
    assign take    = (state_q == ST_IDLE) & req;

    assign unused_ok = ^{wbs_cab_i, wbs_adr_i[31:5+CHW], wbs_adr_i[1:0]};

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        assign wr_en[n] = take & wbs_we_i & (32'(chan) == 32'(n));
        wbm_chan_regs u_ch (
            .clk_i      (wb_clk_i),
            .rst_n_i    (wb_rst_n_i),
            .wr_en_i    (wr_en[n]),
            .word_i     (word),
            .sel_i      (wbs_sel_i),
            .dat_i      (wbs_dat_i),
            .done_i     (ch_done_i[n]),
            .err_i      (ch_err_i[n]),
            .state_i    (sg_state_i[n*8 +: 8]),
            .desc_i     (sg_desc_i[n*16 +: 16]),
            .addr_i     (sg_addr_i[n*29 +: 29]),
            .next_i     (sg_next_i[n*29 +: 29]),
            .rd_dat_o   (rd_dat[n]),
            .ccr_o      (ccr_o[n*32 +: 32]),
            .dar_o      (dar_o[n*29 +: 29]),
            .ndar_o     (ndar_o[n*29 +: 29]),
            .start_o    (start_o[n]),
            .irq_term_o (irq_term[n])
        );
    end

    always_comb begin
        rd_sel = '0;
        for (int n = 0; n < NCH; n++) begin
            if (32'(chan) == 32'(n)) rd_sel = rd_dat[n];
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_RESP;
                    ack_d   = chan_ok;
                    err_d   = ~chan_ok;
                    dat_d   = chan_ok ? rd_sel : 32'h0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            irq_q   <= |irq_term;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbs_dat_o = dat_q;
    assign wbs_rty_o = 1'b0;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_wbm_regs.sv
module tb_wbm_regs;

    localparam int NCH = 4;
    localparam int CHW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0, cab = 1'b0;
    logic [3:0]        sel = '0;
    logic [31:0]       adr = '0, wdat = '0;
    logic [31:0]       dat_o;
    logic              ack_o, err_o, rty_o;
    logic [NCH*8-1:0]  sg_state = '0;
    logic [NCH*16-1:0] sg_desc = '0;
    logic [NCH*29-1:0] sg_addr = '0, sg_next = '0;
    logic [NCH-1:0]    ch_done = '0, ch_err = '0;
    logic [NCH*32-1:0] ccr_o;
    logic [NCH*29-1:0] dar_o, ndar_o;
    logic [NCH-1:0]    start_o;
    logic              irq_o;

    int checks = 0;
    int failures = 0;

    // Reference model: register contents as the software view sees them.
    logic [31:0] m_ccr [NCH];
    logic [31:0] m_dar [NCH];
    logic [31:0] m_ndar[NCH];
    logic        m_done[NCH];
    logic        m_err [NCH];
    logic [7:0]  t_state[NCH];
    logic [15:0] t_desc [NCH];
    logic [28:0] t_addr [NCH];
    logic [28:0] t_next [NCH];

    wbm_regs #(.NCH(NCH), .CHW(CHW)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_cab_i(cab),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_dat_o(dat_o), .wbs_ack_o(ack_o), .wbs_err_o(err_o), .wbs_rty_o(rty_o),
        .sg_state_i(sg_state), .sg_desc_i(sg_desc), .sg_addr_i(sg_addr), .sg_next_i(sg_next),
        .ch_done_i(ch_done), .ch_err_i(ch_err),
        .ccr_o(ccr_o), .dar_o(dar_o), .ndar_o(ndar_o),
        .start_o(start_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_ccr[n] = 0; m_dar[n] = 0; m_ndar[n] = 0; m_done[n] = 0; m_err[n] = 0;
        end
    endtask

    task automatic drive_status(input logic rnd);
        for (int n = 0; n < NCH; n++) begin
            t_state[n] = rnd ? 8'($urandom_range(0, 3) == 0 ? $urandom : 0) : 8'h0;
            t_desc[n]  = rnd ? 16'($urandom) : 16'h0;
            t_addr[n]  = rnd ? 29'($urandom) : 29'h0;
            t_next[n]  = rnd ? 29'($urandom) : 29'h0;
            sg_state[n*8 +: 8]   = t_state[n];
            sg_desc[n*16 +: 16]  = t_desc[n];
            sg_addr[n*29 +: 29]  = t_addr[n];
            sg_next[n*29 +: 29]  = t_next[n];
        end
    endtask

    function automatic logic [31:0] exp_read(input int ch, input int word);
        case (word)
            0: return m_ccr[ch];
            1: return ((t_state[ch] != 0) ? 32'd256 : 32'd0) + (m_err[ch] ? 32'd2 : 32'd0)
                      + (m_done[ch] ? 32'd1 : 32'd0);
            2: return m_dar[ch];
            3: return m_ndar[ch];
            4: return 32'(t_state[ch]);
            5: return 32'(t_desc[ch]);
            6: return 32'(t_addr[ch]) * 8;
            default: return 32'(t_next[ch]) * 8;
        endcase
    endfunction

    function automatic logic [31:0] bytes_into(input logic [31:0] old_v, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    function automatic logic exp_irq();
        for (int n = 0; n < NCH; n++) begin
            if (m_done[n] && m_ccr[n][1]) return 1'b1;
            if (m_err[n]  && m_ccr[n][2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NCH*32-1:0] exp_ccr_vec();
        logic [NCH*32-1:0] v;
        for (int n = 0; n < NCH; n++) v[n*32 +: 32] = m_ccr[n];
        return v;
    endfunction

    function automatic logic [NCH*29-1:0] exp_addr_vec(input logic ndar);
        logic [NCH*29-1:0] v;
        logic [31:0] a;
        for (int n = 0; n < NCH; n++) begin
            a = ndar ? m_ndar[n] : m_dar[n];
            v[n*29 +: 29] = a[31:3];
        end
        return v;
    endfunction

    // One Wishbone access plus optional event pulses in the request cycle.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [NCH-1:0] dn,
                          input logic [NCH-1:0] er, output logic [31:0] rd);
        int ch, word;
        logic ok;
        logic [31:0] exp_rd;
        logic [NCH-1:0] exp_st;
        logic a1, e1, a2, e2;
        logic [NCH-1:0] s1, s2;
        ch = int'(a[7:5]);
        word = int'(a[4:2]);
        ok = (ch < NCH);
        exp_rd = ok ? exp_read(ch, word) : 32'h0;
        exp_st = '0;
        if (ok && w) begin
            case (word)
                0: begin
                    if (s[0] && d[0]) exp_st[ch] = 1'b1;
                    m_ccr[ch] = bytes_into(m_ccr[ch], d, s) & ~32'h1;
                end
                1: if (s[0]) begin
                    if (d[0]) m_done[ch] = 1'b0;
                    if (d[1]) m_err[ch]  = 1'b0;
                end
                2: m_dar[ch]  = bytes_into(m_dar[ch], d, s)  & ~32'h7;
                3: m_ndar[ch] = bytes_into(m_ndar[ch], d, s) & ~32'h7;
                default: ;
            endcase
        end
        for (int n = 0; n < NCH; n++) begin
            if (dn[n]) m_done[n] = 1'b1;
            if (er[n]) m_err[n]  = 1'b1;
        end

        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d; ch_done = dn; ch_err = er;
        @(posedge clk); #1;
        rd = dat_o; a1 = ack_o; e1 = err_o; s1 = start_o;
        @(negedge clk);
        cyc = 0; stb = 0; we = 0; ch_done = '0; ch_err = '0;
        @(posedge clk); #1;
        a2 = ack_o; e2 = err_o; s2 = start_o;

        check("ack", a1, ok);
        check("err", e1, !ok);
        if (!w || !ok) check("rdata", rd, exp_rd);
        check("start_resp", s1, exp_st);
        check("resp_one_cycle", {a2, e2, s2}, '0);
        check("ccr_o", ccr_o, exp_ccr_vec());
        check("dar_o", dar_o, exp_addr_vec(1'b0));
        check("ndar_o", ndar_o, exp_addr_vec(1'b1));
        check("irq", irq_o, exp_irq());
        check("rty", rty_o, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        int nresp;
        model_reset();
        drive_status(1'b0);
        #12;
        check("rst_ack", ack_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_ccr", ccr_o, '0);
        check("rst_irq_start", {irq_o, start_o}, '0);
        @(negedge clk); rst_n = 1;

        // ch2 DAR write/readback
        access(1, 32'h48, 4'hF, 32'hDEADBEE8, '0, '0, rd);
        access(0, 32'h48, 4'h0, 32'h0, '0, '0, rd);
        check("dar_rd", rd, 32'hDEADBEE8);
        check("dar_slice2", dar_o[2*29 +: 29], 29'h1BD5B7DD);

        // byte-lane merge on ch0 CCR
        access(1, 32'h00, 4'hF, 32'h11223300, '0, '0, rd);
        access(1, 32'h00, 4'b0010, 32'h0000AB00, '0, '0, rd);
        access(0, 32'h00, 4'h0, 32'h0, '0, '0, rd);
        check("ccr_merge", rd, 32'h1122AB00);

        // start pulse, done event, irq enable and clear on ch1
        access(1, 32'h20, 4'hF, 32'h5, '0, '0, rd);
        access(0, 32'h20, 4'hF, 32'h0, '0, '0, rd);
        check("ccr_start_rd0", rd, 32'h4);
        access(0, 32'h3C, 4'hF, 32'h0, 4'b0010, '0, rd);
        access(0, 32'h24, 4'hF, 32'h0, '0, '0, rd);
        check("csr_done", rd, 32'h1);
        check("irq_masked", irq_o, 1'b0);
        access(1, 32'h20, 4'hF, 32'h2, '0, '0, rd);
        check("irq_on", irq_o, 1'b1);
        access(1, 32'h24, 4'hF, 32'h1, '0, '0, rd);
        check("irq_cleared", irq_o, 1'b0);

        // set wins over a simultaneous w1c on ch0 ERR
        access(0, 32'h0C, 4'hF, 32'h0, '0, 4'b0001, rd);
        access(1, 32'h04, 4'hF, 32'h2, '0, 4'b0001, rd);
        access(0, 32'h04, 4'hF, 32'h0, '0, '0, rd);
        check("err_set_wins", rd, 32'h2);

        // out-of-range channel, write attempt must not change anything
        access(1, 32'hA0, 4'hF, 32'hFFFFFFFF, '0, '0, rd);
        check("oob_dat", rd, 32'h0);

        // cyc&stb held six cycles
        nresp = 0;
        @(negedge clk); cyc = 1; stb = 1; we = 0; adr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack_o || err_o) nresp++;
        end
        @(negedge clk); cyc = 0; stb = 0;
        check("held_stb_resp", nresp, 3);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [NCH-1:0] dn, er;
            drive_status(1'b1);
            a = ($urandom & 32'hFFFFFF00) | (32'($urandom_range(0, 5)) << 5)
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            dn = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            er = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            access(1'($urandom), a, 4'($urandom), $urandom, dn, er, rd);
        end

        // reset during RESP
        @(negedge clk); cyc = 1; stb = 1; we = 1; adr = 32'h20; sel = 4'hF; wdat = 32'hFFFFFFF6;
        @(posedge clk); #1;
        check("pre_rst_ack", ack_o, 1'b1);
        #2 rst_n = 0;
        #1;
        check("rst_async_resp", {ack_o, err_o, dat_o}, '0);
        check("rst_regs", {ccr_o, dar_o, ndar_o}, '0);
        check("rst_irq", irq_o, 1'b0);
        model_reset();
        @(negedge clk); cyc = 0; stb = 0; we = 0;
        @(negedge clk); rst_n = 1;
        access(1, 32'h6C, 4'hF, 32'h12345678, '0, '0, rd);
        access(0, 32'h6C, 4'h0, 32'h0, '0, '0, rd);
        check("post_rst_rd", rd, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
